// File: rtl/hc_pkg.sv
// Shared types for the host-channel read path: request control word, arbiter tag
// and response-router state.
package hc_pkg;

  localparam int HC_ARB_PORTS_DEFAULT     = 4;
  localparam int HC_ARB_TAG_DEPTH_DEFAULT = 16;
  localparam int HC_ARB_PORT_W            = 3;
  localparam int HC_CL_BITS               = 512;

  typedef enum logic [1:0] {
    e_REQUEST_NONE         = 2'd0,
    e_REQUEST_READ_STREAM  = 2'd1,
    e_REQUEST_READ_INDEXED = 2'd2,
    e_REQUEST_WRITE        = 2'd3
  } t_request_cmd;

  typedef logic [7:0]  t_request_cmd_size;
  typedef logic [7:0]  t_request_id;
  typedef logic [31:0] t_request_offset;

  typedef struct packed {
    t_request_cmd      cmd;
    t_request_id       id;
    t_request_offset   offset;
    t_request_cmd_size size;
  } t_request_control;

  typedef struct packed {
    logic [HC_ARB_PORT_W-1:0] port;
    t_request_cmd_size        lines;
  } t_arb_tag;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_ROUTE = 1'b1
  } t_arb_rsp_state;

  // Zero-length streams and non-read commands are swallowed without a tag.
  function automatic logic hc_is_forwarded(t_request_control c);
    return (c.cmd == e_REQUEST_READ_INDEXED) ||
           ((c.cmd == e_REQUEST_READ_STREAM) && (c.size != '0));
  endfunction

  function automatic t_request_cmd_size hc_tag_lines(t_request_control c);
    return (c.cmd == e_REQUEST_READ_STREAM) ? c.size : t_request_cmd_size'(1);
  endfunction

endpackage

// File: rtl/hc_read_arbiter_if.sv
// Port bundle between the core read requesters, the requestor read queue and
// the routed response path.
interface hc_read_arbiter_if import hc_pkg::*; #(
  parameter int PORTS = HC_ARB_PORTS_DEFAULT
);
  logic [PORTS-1:0]                   req_valid;
  logic [PORTS-1:0]                   req_ready;
  t_request_control [PORTS-1:0]       req_ctrl;
  t_request_control                   out_ctrl;
  logic                               out_full;
  logic                               rx_valid;
  logic [HC_CL_BITS-1:0]              rx_data;
  logic [PORTS-1:0]                   rsp_valid;
  logic [HC_CL_BITS-1:0]              rsp_data;
  logic                               err_orphan;

  modport master (
    output req_valid, req_ctrl, out_full, rx_valid, rx_data,
    input  req_ready, out_ctrl, rsp_valid, rsp_data, err_orphan
  );

  modport slave (
    input  req_valid, req_ctrl, out_full, rx_valid, rx_data,
    output req_ready, out_ctrl, rsp_valid, rsp_data, err_orphan
  );
endinterface

// File: rtl/hc_fifo.sv
// Small synchronous FIFO with first-word fall-through read data; pushes while
// full and pops while empty are ignored.
module hc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/hc_read_arbiter.sv
// Round-robin arbiter for core read requests toward the requestor read queue,
// with an in-order tag FIFO that steers returning lines back to their port.
//
// state   | meaning
// R_IDLE  | no head tag loaded; responses with an empty tag FIFO are orphans
// R_ROUTE | routing lines to the head tag's port; remaining counts lines left
module hc_read_arbiter import hc_pkg::*; #(
  parameter int HC_ARB_PORTS     = HC_ARB_PORTS_DEFAULT,
  parameter int HC_ARB_TAG_DEPTH = HC_ARB_TAG_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  hc_read_arbiter_if.slave  bus
);
  localparam int PW = (HC_ARB_PORTS > 1) ? $clog2(HC_ARB_PORTS) : 1;
  localparam int CW = $clog2(HC_ARB_TAG_DEPTH) + 1;

  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        grant_idx;
  logic [PW:0]          cand_sum;
  logic                 grant_any;
  t_request_control     grant_ctrl;
  logic                 fwd;

  t_arb_tag             push_tag;
  t_arb_tag             head_tag;
  logic                 tag_push;
  logic                 tag_pop;
  logic                 tag_full;
  logic                 tag_empty;
  logic [CW-1:0]        tag_count;

  t_arb_rsp_state       state, state_nxt;
  t_request_cmd_size    remaining, remaining_nxt, cur_left;
  logic                 route;
  logic                 orphan;
  logic [HC_ARB_PORTS-1:0] head_onehot;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    if (!reset && !bus.out_full && !tag_full) begin
      for (int k = 0; k < HC_ARB_PORTS; k++) begin
        cand_sum = {1'b0, rr_ptr} + (PW+1)'(k);
        if (cand_sum >= (PW+1)'(HC_ARB_PORTS)) cand_sum = cand_sum - (PW+1)'(HC_ARB_PORTS);
        if (!grant_any && bus.req_valid[cand_sum[PW-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand_sum[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant_any) bus.req_ready[grant_idx] = 1'b1;
  end

  assign grant_ctrl     = bus.req_ctrl[grant_idx];
  assign fwd            = grant_any && hc_is_forwarded(grant_ctrl);
  assign tag_push       = fwd;
  assign push_tag.port  = HC_ARB_PORT_W'(grant_idx);
  assign push_tag.lines = hc_tag_lines(grant_ctrl);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr       <= '0;
      bus.out_ctrl <= '0;
    end else begin
      if (grant_any) rr_ptr <= (grant_idx == PW'(HC_ARB_PORTS-1)) ? '0 : grant_idx + 1'b1;
      if (fwd) bus.out_ctrl <= grant_ctrl;
      else     bus.out_ctrl <= '0;
    end
  end

  hc_fifo #(
    .WIDTH ($bits(t_arb_tag)),
    .DEPTH (HC_ARB_TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_push),
    .push_data (push_tag),
    .pop       (tag_pop),
    .pop_data  (head_tag),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  // remaining==0 in R_ROUTE means a fresh head was just exposed by a pop.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    tag_pop       = 1'b0;
    route         = 1'b0;
    orphan        = 1'b0;
    cur_left      = (state == R_ROUTE && remaining != '0) ? remaining : head_tag.lines;
    if (bus.rx_valid) begin
      if (tag_empty) begin
        orphan = 1'b1;
      end else begin
        route = 1'b1;
        if (cur_left == t_request_cmd_size'(1)) begin
          tag_pop       = 1'b1;
          remaining_nxt = '0;
          state_nxt     = (tag_count > CW'(1) || tag_push) ? R_ROUTE : R_IDLE;
        end else begin
          remaining_nxt = cur_left - 1'b1;
          state_nxt     = R_ROUTE;
        end
      end
    end else if (state == R_IDLE && !tag_empty) begin
      state_nxt     = R_ROUTE;
      remaining_nxt = head_tag.lines;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= R_IDLE;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    head_onehot = '0;
    for (int i = 0; i < HC_ARB_PORTS; i++)
      head_onehot[i] = (head_tag.port == HC_ARB_PORT_W'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rsp_valid  <= '0;
      bus.rsp_data   <= '0;
      bus.err_orphan <= 1'b0;
    end else begin
      bus.rsp_valid <= route ? head_onehot : '0;
      if (bus.rx_valid) bus.rsp_data <= bus.rx_data;
      if (orphan) bus.err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hc_read_arbiter.sv
// Scenario and randomized checks of hc_read_arbiter against a queue-based
// model of grants, forwarded requests and in-order response routing.
module tb_hc_read_arbiter;
  import hc_pkg::*;

  localparam int P = 4;
  localparam int D = 16;

  logic clk = 1'b0;
  logic reset;

  hc_read_arbiter_if #(.PORTS(P)) bus();

  hc_read_arbiter #(.HC_ARB_PORTS(P), .HC_ARB_TAG_DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model: pointer, outstanding tags as (port, lines), lines already returned for head
  int m_rr, m_done, m_grant;
  int q_port[$];
  int q_lines[$];
  logic [P-1:0]     exp_ready;
  t_request_control exp_out;
  logic [P-1:0]     exp_rsp_valid;
  logic [511:0]     exp_rsp_data;
  logic             exp_err;

  function automatic int fwd_lines(t_request_control c);
    if (c.cmd == e_REQUEST_READ_INDEXED) return 1;
    if (c.cmd == e_REQUEST_READ_STREAM)  return int'(c.size);
    return 0;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  function automatic t_request_control mk_ctrl(t_request_cmd cmd, int id, int off, int size);
    t_request_control c;
    c.cmd    = cmd;
    c.id     = t_request_id'(id);
    c.offset = t_request_offset'(off);
    c.size   = t_request_cmd_size'(size);
    return c;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_done = 0; m_grant = -1;
    q_port.delete(); q_lines.delete();
    exp_out = '0; exp_rsp_valid = '0; exp_rsp_data = '0; exp_err = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_ctrl  = '0;
    bus.out_full  = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = '0;
  endtask

  // Let combinational outputs settle and work out which port should be granted.
  task automatic settle();
    #1;
    m_grant   = -1;
    exp_ready = '0;
    if (!bus.out_full && q_port.size() < D)
      for (int k = 0; k < P; k++)
        if (m_grant < 0 && bus.req_valid[(m_rr + k) % P]) m_grant = (m_rr + k) % P;
    if (m_grant >= 0) exp_ready[m_grant] = 1'b1;
  endtask

  task automatic tick();
    t_request_control c;
    logic rxv;
    logic [511:0] rxd;
    int g;
    g   = m_grant;
    rxv = bus.rx_valid;
    rxd = bus.rx_data;
    c   = '0;
    if (g >= 0) c = bus.req_ctrl[g];
    @(posedge clk);
    exp_rsp_valid = '0;
    if (rxv) begin
      exp_rsp_data = rxd;
      if (q_port.size() == 0) exp_err = 1'b1;
      else begin
        exp_rsp_valid[q_port[0]] = 1'b1;
        m_done++;
        if (m_done == q_lines[0]) begin
          void'(q_port.pop_front());
          void'(q_lines.pop_front());
          m_done = 0;
        end
      end
    end
    exp_out = '0;
    if (g >= 0) begin
      m_rr = (g + 1) % P;
      if (fwd_lines(c) > 0) begin
        exp_out = c;
        q_port.push_back(g);
        q_lines.push_back(fwd_lines(c));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.req_valid = '1;
    for (int p = 0; p < P; p++) bus.req_ctrl[p] = mk_ctrl(e_REQUEST_READ_INDEXED, p, 5, 1);
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (bus.req_ready !== '0) begin n_err++; $display("FAIL reset_req_ready: got %b, expected 0", bus.req_ready); end
    n_vec++; if (bus.out_ctrl !== '0) begin n_err++; $display("FAIL reset_out_ctrl: got %h, expected 0", bus.out_ctrl); end
    n_vec++; if (bus.rsp_valid !== '0) begin n_err++; $display("FAIL reset_rsp_valid: got %b, expected 0", bus.rsp_valid); end
    n_vec++; if (bus.rsp_data !== '0) begin n_err++; $display("FAIL reset_rsp_data: got %h, expected 0", bus.rsp_data); end
    n_vec++; if (bus.err_orphan !== 1'b0) begin n_err++; $display("FAIL reset_err_orphan: got %b, expected 0", bus.err_orphan); end
    idle_inputs();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_rr_indexed();
    logic [P-1:0] want;
    for (int p = 0; p < P; p++) bus.req_ctrl[p] = mk_ctrl(e_REQUEST_READ_INDEXED, 16 + p, 5, $urandom_range(0, 7));
    bus.req_valid = '1;
    for (int k = 0; k < P; k++) begin
      settle();
      want = '0; want[k] = 1'b1;
      n_vec++; if (bus.req_ready !== want || bus.req_ready !== exp_ready) begin n_err++; $display("FAIL rr_grant: got %b, expected %b", bus.req_ready, want); end
      tick();
      bus.req_valid[k] = 1'b0;
      n_vec++; if (bus.out_ctrl !== exp_out || bus.out_ctrl.offset !== 32'd5) begin n_err++; $display("FAIL rr_out_ctrl: got %h, expected %h", bus.out_ctrl, exp_out); end
    end
    bus.rx_valid = 1'b1;
    for (int k = 0; k < P; k++) begin
      bus.rx_data = rand_line();
      settle(); tick();
      want = '0; want[k] = 1'b1;
      n_vec++; if (bus.rsp_valid !== want || bus.rsp_valid !== exp_rsp_valid) begin n_err++; $display("FAIL rr_rsp_valid: got %b, expected %b", bus.rsp_valid, want); end
      n_vec++; if (bus.rsp_data !== exp_rsp_data) begin n_err++; $display("FAIL rr_rsp_data: got %h, expected %h", bus.rsp_data, exp_rsp_data); end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_stream_routing();
    logic [P-1:0] want;
    bus.req_ctrl[2] = mk_ctrl(e_REQUEST_READ_STREAM, 2, 64, 4);
    bus.req_ctrl[0] = mk_ctrl(e_REQUEST_READ_INDEXED, 0, 9, 0);
    bus.req_valid = 4'b0100;
    settle();
    n_vec++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL stream_grant2: got %b, expected 0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0001;
    n_vec++; if (bus.out_ctrl !== exp_out) begin n_err++; $display("FAIL stream_out2: got %h, expected %h", bus.out_ctrl, exp_out); end
    settle();
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL stream_grant0: got %b, expected 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    n_vec++; if (bus.out_ctrl !== exp_out) begin n_err++; $display("FAIL stream_out0: got %h, expected %h", bus.out_ctrl, exp_out); end
    bus.rx_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.rx_data = rand_line();
      settle(); tick();
      want = (k < 4) ? 4'b0100 : 4'b0001;
      n_vec++; if (bus.rsp_valid !== want || bus.rsp_valid !== exp_rsp_valid) begin n_err++; $display("FAIL stream_rsp_valid: got %b, expected %b", bus.rsp_valid, want); end
      n_vec++; if (bus.rsp_data !== exp_rsp_data) begin n_err++; $display("FAIL stream_rsp_data: got %h, expected %h", bus.rsp_data, exp_rsp_data); end
    end
    bus.rx_valid = 1'b0;
    settle(); tick();
    n_vec++; if (bus.rsp_valid !== '0) begin n_err++; $display("FAIL stream_rsp_idle: got %b, expected 0", bus.rsp_valid); end
  endtask

  task automatic test_out_full();
    for (int p = 0; p < P; p++) bus.req_ctrl[p] = mk_ctrl(e_REQUEST_WRITE, p, 0, 1);
    bus.req_valid = '1;
    bus.out_full  = 1'b1;
    repeat (10) begin
      settle();
      n_vec++; if (bus.req_ready !== '0) begin n_err++; $display("FAIL full_req_ready: got %b, expected 0", bus.req_ready); end
      tick();
      n_vec++; if (bus.out_ctrl.cmd !== e_REQUEST_NONE) begin n_err++; $display("FAIL full_out_cmd: got %0d, expected 0", bus.out_ctrl.cmd); end
    end
    bus.out_full = 1'b0;
    settle();
    n_vec++; if (bus.req_ready !== exp_ready || exp_ready[m_rr] !== 1'b1) begin n_err++; $display("FAIL full_release_grant: got %b, expected %b", bus.req_ready, exp_ready); end
    tick();
    bus.req_valid = '0;
    n_vec++; if (bus.out_ctrl !== '0) begin n_err++; $display("FAIL full_write_dropped: got %h, expected 0", bus.out_ctrl); end
  endtask

  task automatic test_tag_full();
    int p;
    for (int n = 0; n < D; n++) begin
      p = $urandom_range(0, P-1);
      bus.req_valid = '0; bus.req_valid[p] = 1'b1;
      bus.req_ctrl[p] = mk_ctrl(e_REQUEST_READ_INDEXED, n, n, 1);
      settle();
      n_vec++; if (bus.req_ready !== bus.req_valid || bus.req_ready !== exp_ready) begin n_err++; $display("FAIL tagfill_grant: got %b, expected %b", bus.req_ready, exp_ready); end
      tick();
    end
    bus.req_valid = '1;
    for (int q = 0; q < P; q++) bus.req_ctrl[q] = mk_ctrl(e_REQUEST_READ_INDEXED, 99, q, 1);
    repeat (3) begin
      settle();
      n_vec++; if (bus.req_ready !== '0) begin n_err++; $display("FAIL tagfull_blocked: got %b, expected 0", bus.req_ready); end
      tick();
    end
    bus.rx_valid = 1'b1; bus.rx_data = rand_line();
    settle();
    n_vec++; if (bus.req_ready !== '0) begin n_err++; $display("FAIL tagfull_pop_cycle: got %b, expected 0", bus.req_ready); end
    tick();
    bus.rx_valid = 1'b0;
    n_vec++; if (bus.rsp_valid !== exp_rsp_valid) begin n_err++; $display("FAIL tagfull_rsp: got %b, expected %b", bus.rsp_valid, exp_rsp_valid); end
    settle();
    n_vec++; if (bus.req_ready !== exp_ready || exp_ready === '0) begin n_err++; $display("FAIL tagfull_regrant: got %b, expected %b", bus.req_ready, exp_ready); end
    tick();
    bus.req_valid = '0;
    bus.rx_valid = 1'b1;
    repeat (D) begin
      bus.rx_data = rand_line();
      settle(); tick();
      n_vec++; if (bus.rsp_valid !== exp_rsp_valid || exp_rsp_valid === '0) begin n_err++; $display("FAIL tagdrain_rsp: got %b, expected %b", bus.rsp_valid, exp_rsp_valid); end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_orphan_zero();
    bus.rx_valid = 1'b1; bus.rx_data = rand_line();
    settle(); tick();
    bus.rx_valid = 1'b0;
    n_vec++; if (bus.rsp_valid !== '0) begin n_err++; $display("FAIL orphan_rsp_valid: got %b, expected 0", bus.rsp_valid); end
    n_vec++; if (bus.err_orphan !== 1'b1 || exp_err !== 1'b1) begin n_err++; $display("FAIL orphan_err: got %b, expected 1", bus.err_orphan); end
    bus.req_ctrl[3] = mk_ctrl(e_REQUEST_READ_STREAM, 3, 128, 0);
    bus.req_valid = 4'b1000;
    settle();
    n_vec++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL zero_stream_ready: got %b, expected 1000", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    n_vec++; if (bus.out_ctrl !== '0) begin n_err++; $display("FAIL zero_stream_out: got %h, expected 0", bus.out_ctrl); end
    settle();
    n_vec++; if (bus.err_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_sticky: got %b, expected 1", bus.err_orphan); end
    tick();
  endtask

  task automatic test_reset_midop();
    bus.req_ctrl[1] = mk_ctrl(e_REQUEST_READ_STREAM, 1, 0, 3);
    bus.req_valid = 4'b0010;
    settle(); tick();
    bus.req_valid = '0;
    reset = 1'b1;
    #1;
    n_vec++; if (bus.err_orphan !== 1'b0 || bus.out_ctrl !== '0) begin n_err++; $display("FAIL midreset_clear: got err=%b out=%h, expected 0", bus.err_orphan, bus.out_ctrl); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    bus.rx_valid = 1'b1; bus.rx_data = rand_line();
    settle(); tick();
    bus.rx_valid = 1'b0;
    n_vec++; if (bus.err_orphan !== 1'b1 || bus.rsp_valid !== '0) begin n_err++; $display("FAIL midreset_orphan: got err=%b rsp=%b, expected 1/0", bus.err_orphan, bus.rsp_valid); end
  endtask

  task automatic test_random();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle_inputs();
    repeat (600) begin
      bus.req_valid = P'($urandom_range(0, (1 << P) - 1));
      for (int p = 0; p < P; p++)
        bus.req_ctrl[p] = mk_ctrl(t_request_cmd'($urandom_range(0, 3)), $urandom_range(0, 255), $urandom(), $urandom_range(0, 4));
      bus.out_full = ($urandom_range(0, 4) == 0);
      bus.rx_valid = ($urandom_range(0, 2) == 0);
      bus.rx_data  = rand_line();
      settle();
      n_vec++; if (bus.req_ready !== exp_ready) begin n_err++; $display("FAIL rand_req_ready: got %b, expected %b", bus.req_ready, exp_ready); end
      tick();
      n_vec++; if (bus.out_ctrl !== exp_out) begin n_err++; $display("FAIL rand_out_ctrl: got %h, expected %h", bus.out_ctrl, exp_out); end
      n_vec++; if (bus.rsp_valid !== exp_rsp_valid) begin n_err++; $display("FAIL rand_rsp_valid: got %b, expected %b", bus.rsp_valid, exp_rsp_valid); end
      n_vec++; if (bus.rsp_data !== exp_rsp_data) begin n_err++; $display("FAIL rand_rsp_data: got %h, expected %h", bus.rsp_data, exp_rsp_data); end
      n_vec++; if (bus.err_orphan !== exp_err) begin n_err++; $display("FAIL rand_err_orphan: got %b, expected %b", bus.err_orphan, exp_err); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_rr_indexed();
    test_stream_routing();
    test_out_full();
    test_tag_full();
    test_orphan_zero();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
